// File: rtl/i2c_write_target.sv
// i2c_write_target: write-only I2C target that accepts a two-byte register
// write (7-bit register address + 9-bit data) addressed to DEV_ADDR.
//
// Ports:
//   i_clk       system clock, all logic on the rising edge
//   i_rst       synchronous active-high reset
//   i_sclk      raw SCL line
//   i_sdat      raw SDA line
//   o_sdat_oen  1 = pull SDA low (ACK), 0 = release
//   o_valid     one-cycle pulse when a complete write is accepted on STOP
//   o_reg_addr  register address of the last accepted write
//   o_reg_data  register data of the last accepted write
//   o_err       one-cycle pulse on protocol error
//   i_rd_addr   shadow register read index
//   o_rd_data   shadow register read data
//
// Optional feature: define I2C_TARGET_SHADOW_EN to build ten 9-bit shadow
// registers readable through i_rd_addr/o_rd_data. Without it o_rd_data is 0.
module i2c_write_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h1A,
    parameter int unsigned MIN_HALF = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_sdat,
    output logic       o_sdat_oen,
    output logic       o_valid,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_err,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_BYTE1, S_ACK1,
        S_BYTE2, S_ACK2, S_WAIT_STOP, S_IGNORE
    } state_t;

    localparam int unsigned HW = $clog2(MIN_HALF + 1);

    logic       scl_meta_q, scl_sync_q, scl_prev_q;
    logic       sda_meta_q, sda_sync_q, sda_prev_q;
    logic       scl_rise, scl_fall, start_det, stop_det;
    state_t     state_q;
    logic [2:0] cnt_q;
    logic [6:0] shift_q;
    logic [7:0] byte_d;
    logic       byte_done, counting;
    logic       oen_q, valid_q, err_q;
    logic [6:0] addr_tmp_q, reg_addr_q;
    logic       d8_tmp_q;
    logic [7:0] lo_tmp_q;
    logic [8:0] reg_data_q;
    logic [HW-1:0] half_cnt_q;

    // Synchronizers and edge-detect flop all reset high (idle bus).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_meta_q <= 1'b1; scl_sync_q <= 1'b1; scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1; sda_sync_q <= 1'b1; sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= i_sclk; scl_sync_q <= scl_meta_q; scl_prev_q <= scl_sync_q;
            sda_meta_q <= i_sdat; sda_sync_q <= sda_meta_q; sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    // SCL must be high on both sides so a simultaneous SCL/SDA change is not a START/STOP.
    assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

    assign byte_d    = {shift_q, sda_sync_q};
    assign byte_done = scl_rise && (cnt_q == 3'd7);
    assign counting  = (state_q == S_ADDR) || (state_q == S_BYTE1) ||
                       (state_q == S_BYTE2) || (state_q == S_WAIT_STOP);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            oen_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            addr_tmp_q <= '0;
            d8_tmp_q   <= 1'b0;
            lo_tmp_q   <= '0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (scl_rise) begin
                shift_q <= {shift_q[5:0], sda_sync_q};
            end
            if (start_det) begin
                state_q <= S_ADDR;
                cnt_q   <= '0;
                oen_q   <= 1'b0;
            end else if (stop_det) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                oen_q   <= 1'b0;
                case (state_q)
                    S_ADDR_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2: err_q <= 1'b1;
                    S_WAIT_STOP: begin
                        valid_q    <= 1'b1;
                        reg_addr_q <= addr_tmp_q;
                        reg_data_q <= {d8_tmp_q, lo_tmp_q};
                    end
                    default: ;
                endcase
            end else begin
                if (scl_rise && counting) begin
                    cnt_q <= cnt_q + 3'd1;
                end
                case (state_q)
                    S_ADDR: if (byte_done) begin
                        state_q <= (byte_d == {DEV_ADDR, 1'b0}) ? S_ADDR_ACK : S_IGNORE;
                    end
                    // First SCL fall (end of bit 8) starts the ACK, the next one ends it.
                    S_ADDR_ACK, S_ACK1, S_ACK2: if (scl_fall) begin
                        if (!oen_q) begin
                            oen_q <= 1'b1;
                        end else begin
                            oen_q <= 1'b0;
                            cnt_q <= '0;
                            case (state_q)
                                S_ADDR_ACK: state_q <= S_BYTE1;
                                S_ACK1:     state_q <= S_BYTE2;
                                default:    state_q <= S_WAIT_STOP;
                            endcase
                        end
                    end
                    S_BYTE1: if (byte_done) begin
                        addr_tmp_q <= byte_d[7:1];
                        d8_tmp_q   <= byte_d[0];
                        state_q    <= S_ACK1;
                    end
                    S_BYTE2: if (byte_done) begin
                        lo_tmp_q <= byte_d;
                        state_q  <= S_ACK2;
                    end
                    S_WAIT_STOP: if (byte_done) begin
                        err_q   <= 1'b1;
                        state_q <= S_IGNORE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Cycles since the last synced SCL edge, saturating at MIN_HALF; used only
    // to flag a bus clocked faster than the target was sized for.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            half_cnt_q <= HW'(MIN_HALF);
        end else if (scl_rise || scl_fall) begin
            assert (half_cnt_q >= HW'(MIN_HALF));
            half_cnt_q <= HW'(1);
        end else if (half_cnt_q < HW'(MIN_HALF)) begin
            half_cnt_q <= half_cnt_q + HW'(1);
        end
    end

    assign o_sdat_oen = oen_q;
    assign o_valid    = valid_q;
    assign o_err      = err_q;
    assign o_reg_addr = reg_addr_q;
    assign o_reg_data = reg_data_q;

`ifdef I2C_TARGET_SHADOW_EN
    logic [8:0] shadow_q [10];

    // Updated the cycle after o_valid from the freshly latched write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 10; i++) shadow_q[i] <= '0;
        end else if (valid_q) begin
            if (reg_addr_q < 7'd10) begin
                shadow_q[reg_addr_q[3:0]] <= reg_data_q;
            end else if (reg_addr_q == 7'h0F) begin
                for (int unsigned i = 0; i < 10; i++) shadow_q[i] <= '0;
            end
        end
    end

    assign o_rd_data = (i_rd_addr < 4'd10) ? shadow_q[i_rd_addr] : '0;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^i_rd_addr;
    assign o_rd_data      = '0;
`endif

endmodule

// File: tb/tb_i2c_write_target.sv
module tb_i2c_write_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sdat_line;
    logic       oen, valid, err;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;

    int checks   = 0;
    int failures = 0;

    int valid_cnt = 0, err_cnt = 0, oen_cnt = 0, run = 0, max_run = 0;

    // Open-drain bus: the line is low if either side pulls it low.
    assign sdat_line = sda_m & ~oen;

    always #5 clk = ~clk;

    i2c_write_target #(.DEV_ADDR(7'h1A), .MIN_HALF(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(scl_m), .i_sdat(sdat_line),
        .o_sdat_oen(oen), .o_valid(valid), .o_reg_addr(reg_addr),
        .o_reg_data(reg_data), .o_err(err), .i_rd_addr(rd_addr), .o_rd_data(rd_data)
    );

    always @(posedge clk) begin
        if (valid) valid_cnt <= valid_cnt + 1;
        if (err)   err_cnt   <= err_cnt + 1;
        if (oen)   oen_cnt   <= oen_cnt + 1;
        run <= valid ? run + 1 : 0;
        if (valid && (run + 1 > max_run)) max_run <= run + 1;
    end

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wt(8);
        scl_m = 1'b1; wt(16);
        scl_m = 1'b0; wt(8);
    endtask

    // Ends with SCL low, 8 cycles after the 9th falling edge.
    task automatic send_byte(input logic [7:0] b, output logic ack, output logic rel);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wt(8);
        scl_m = 1'b1; wt(8);
        ack = ~sdat_line;
        wt(8);
        scl_m = 1'b0; wt(8);
        rel = oen;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wt(8);
        scl_m = 1'b1; wt(16);
        sda_m = 1'b0; wt(16);
        scl_m = 1'b0; wt(8);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wt(8);
        scl_m = 1'b1; wt(16);
        sda_m = 1'b1; wt(16);
    endtask

    initial begin
        logic ack, rel;
        int v0, e0, o0;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = 4'd9;
        wt(3);
        chk("rst_oen", oen, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_data", reg_data, 0);
        chk("rst_rd", rd_data, 0);
        rst = 1'b0; wt(20);

        // Basic write: reg 0x04 = 0x015
        v0 = valid_cnt; e0 = err_cnt; o0 = oen_cnt;
        i2c_start();
        send_byte(8'h34, ack, rel); chk("w1_ack0", ack, 1); chk("w1_rel0", rel, 0);
        send_byte(8'h08, ack, rel); chk("w1_ack1", ack, 1); chk("w1_rel1", rel, 0);
        send_byte(8'h15, ack, rel); chk("w1_ack2", ack, 1); chk("w1_rel2", rel, 0);
        chk("w1_no_valid_before_stop", valid_cnt - v0, 0);
        i2c_stop();
        chk("w1_valid", valid_cnt - v0, 1);
        chk("w1_valid_width", max_run, 1);
        chk("w1_err", err_cnt - e0, 0);
        chk("w1_oen_cycles", oen_cnt - o0, 96);
        chk("w1_addr", reg_addr, 7'h04);
        chk("w1_data", reg_data, 9'h015);
        rd_addr = 4'd4; wt(1);
`ifdef I2C_TARGET_SHADOW_EN
        chk("w1_rd4", rd_data, 9'h015);
`else
        chk("w1_rd4_off", rd_data, 0);
`endif

        // Wrong address: never ACKed
        v0 = valid_cnt; e0 = err_cnt; o0 = oen_cnt;
        i2c_start();
        send_byte(8'h36, ack, rel); chk("na_ack0", ack, 0);
        send_byte(8'h00, ack, rel); chk("na_ack1", ack, 0);
        send_byte(8'h97, ack, rel); chk("na_ack2", ack, 0);
        i2c_stop();
        chk("na_oen_cycles", oen_cnt - o0, 0);
        chk("na_valid", valid_cnt - v0, 0);
        chk("na_err", err_cnt - e0, 0);
        chk("na_addr", reg_addr, 7'h04);
        chk("na_data", reg_data, 9'h015);

        // Repeated START mid-transaction
        v0 = valid_cnt; e0 = err_cnt; o0 = oen_cnt;
        i2c_start();
        send_byte(8'h34, ack, rel); chk("rs_ack0", ack, 1);
        send_byte(8'h1E, ack, rel); chk("rs_ack1", ack, 1);
        i2c_start();
        send_byte(8'h34, ack, rel); chk("rs_ack2", ack, 1);
        send_byte(8'h0C, ack, rel); chk("rs_ack3", ack, 1);
        send_byte(8'h00, ack, rel); chk("rs_ack4", ack, 1);
        i2c_stop();
        chk("rs_valid", valid_cnt - v0, 1);
        chk("rs_err", err_cnt - e0, 0);
        chk("rs_oen_cycles", oen_cnt - o0, 160);
        chk("rs_addr", reg_addr, 7'h06);
        chk("rs_data", reg_data, 9'h000);

        // Extra byte after the write: NACK, error, nothing accepted
        v0 = valid_cnt; e0 = err_cnt; o0 = oen_cnt;
        i2c_start();
        send_byte(8'h34, ack, rel); chk("xb_ack0", ack, 1);
        send_byte(8'h00, ack, rel); chk("xb_ack1", ack, 1);
        send_byte(8'h97, ack, rel); chk("xb_ack2", ack, 1);
        send_byte(8'hAA, ack, rel); chk("xb_nack3", ack, 0);
        i2c_stop();
        chk("xb_err", err_cnt - e0, 1);
        chk("xb_valid", valid_cnt - v0, 0);
        chk("xb_oen_cycles", oen_cnt - o0, 96);
        chk("xb_addr", reg_addr, 7'h06);
        chk("xb_data", reg_data, 9'h000);

        // STOP right after the address ACK aborts with an error
        v0 = valid_cnt; e0 = err_cnt;
        i2c_start();
        send_byte(8'h34, ack, rel); chk("ab_ack0", ack, 1);
        i2c_stop();
        chk("ab_err", err_cnt - e0, 1);
        chk("ab_valid", valid_cnt - v0, 0);
        chk("ab_addr", reg_addr, 7'h06);

        // Reset during BYTE2, then a full write to reg 0x07 = 0x042
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h34, ack, rel);
        send_byte(8'h0E, ack, rel);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rst = 1'b1; wt(1);
        chk("mr_oen", oen, 0);
        chk("mr_addr_cleared", reg_addr, 0);
        rst = 1'b0; wt(12);
        i2c_stop();
        chk("mr_no_valid", valid_cnt - v0, 0);
        i2c_start();
        send_byte(8'h34, ack, rel); chk("mr_ack0", ack, 1);
        send_byte(8'h0E, ack, rel); chk("mr_ack1", ack, 1);
        send_byte(8'h42, ack, rel); chk("mr_ack2", ack, 1);
        i2c_stop();
        chk("mr_valid", valid_cnt - v0, 1);
        chk("mr_addr", reg_addr, 7'h07);
        chk("mr_data", reg_data, 9'h042);

`ifdef I2C_TARGET_SHADOW_EN
        // Shadow store then clear-all
        i2c_start();
        send_byte(8'h34, ack, rel);
        send_byte(8'h12, ack, rel);
        send_byte(8'h01, ack, rel);
        i2c_stop();
        rd_addr = 4'd9; wt(1);
        chk("sh_rd9", rd_data, 9'h001);
        rd_addr = 4'd7; wt(1);
        chk("sh_rd7", rd_data, 9'h042);
        rd_addr = 4'd12; wt(1);
        chk("sh_rd12", rd_data, 0);
        i2c_start();
        send_byte(8'h34, ack, rel);
        send_byte(8'h1E, ack, rel);
        send_byte(8'h00, ack, rel);
        i2c_stop();
        rd_addr = 4'd9; wt(1);
        chk("sh_rd9_clr", rd_data, 9'h000);
`else
        rd_addr = 4'd7; wt(1);
        chk("off_rd7", rd_data, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
